// File: rtl/mant_div_pkg.sv
// Shared types and constants for the iterative mantissa divider.
package mant_div_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   localparam int MANT_W_SP = 24;
   localparam int MANT_W_DP = 53;

   // Accept-to-result latency of a full-length (non-zero divisor) divide.
   function automatic int lat(input int w);
      return 2 * w - 1;
   endfunction

endpackage

// File: rtl/mant_div_step.sv
// One restoring-division step: compare R against B and conditionally subtract.
module mant_div_step #(
   parameter int RW = 25
) (
   input  logic [RW-1:0] r_i,
   input  logic [RW-1:0] b_i,
   output logic          qbit_o,
   output logic [RW-1:0] r_o
);

   always_comb begin
      qbit_o = (r_i >= b_i);
      r_o    = qbit_o ? (r_i - b_i) : r_i;
   end

endmodule

// File: rtl/mant_div_seq.sv
// Sequential restoring mantissa divider, one quotient bit per clock.
// Optional MANT_DIV_EARLY_EXIT_EN: finish as soon as the remainder reaches zero.
module mant_div_seq
   import mant_div_pkg::*;
#(
   parameter int W  = 24,
   parameter int QW = 2 * W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  a_man,
   input  logic [W-1:0]  b_man,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [QW-1:0] q,
   output logic          sticky,
   output logic          div_zero
);

   localparam int RW = W + 1;
   localparam int CW = $clog2(QW);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] rem_q, rem_d;
   logic [RW-1:0] b_q, b_d;
   logic [QW-1:0] q_q, q_d;
   logic          sticky_q, sticky_d;
   logic          dz_q, dz_d;

   logic          qbit;
   logic [RW-1:0] r_sub;

   mant_div_step #(.RW(RW)) u_step (
      .r_i   (rem_q),
      .b_i   (b_q),
      .qbit_o(qbit),
      .r_o   (r_sub)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      b_d       = b_q;
      q_d       = q_q;
      sticky_d  = sticky_q;
      dz_d      = dz_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               b_d      = {1'b0, b_man};
               sticky_d = 1'b0;
               if (b_man == '0) begin
                  q_d     = '1;
                  dz_d    = 1'b1;
                  rem_d   = '0;
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  q_d     = '0;
                  dz_d    = 1'b0;
                  rem_d   = {1'b0, a_man};
                  cnt_d   = CW'(QW - 2);
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            q_d[cnt_q] = qbit;
            rem_d      = r_sub << 1;
            // Last step keeps the unshifted remainder so sticky sees the true residue.
            if (cnt_q == '0) begin
               rem_d    = r_sub;
               sticky_d = |r_sub;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
`ifdef MANT_DIV_EARLY_EXIT_EN
            if (qbit && (r_sub == '0)) begin
               rem_d    = '0;
               sticky_d = 1'b0;
               state_d  = DONE;
            end
`endif
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         b_q      <= '0;
         q_q      <= '0;
         sticky_q <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         b_q      <= b_d;
         q_q      <= q_d;
         sticky_q <= sticky_d;
         dz_q     <= dz_d;
      end
   end

   assign q        = q_q;
   assign sticky   = sticky_q;
   assign div_zero = dz_q;

endmodule

// File: tb/tb_mant_div_seq.sv
// Scoreboard bench for mant_div_seq: directed, random, div-by-zero, stall and reset cases.
module tb_mant_div_seq;
   import mant_div_pkg::*;

   localparam int W  = MANT_W_SP;
   localparam int QW = 2 * W;
`ifdef MANT_DIV_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif
   localparam int FULL = lat(W);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [W-1:0]  a_man = '0;
   logic [W-1:0]  b_man = '0;
   logic          in_ready, out_valid, sticky, div_zero;
   logic [QW-1:0] q;

   typedef struct {
      logic [QW-1:0] q;
      logic          sticky;
      logic          dz;
      int            lat;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mant_div_seq #(.W(W), .QW(QW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a_man    (a_man),
      .b_man    (b_man),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .q        (q),
      .sticky   (sticky),
      .div_zero (div_zero)
   );

   // Reference: exact integer quotient/remainder; early-exit latency follows from
   // the lowest set quotient bit when the division is exact.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      logic [127:0] num;
      int k;
      if (b == '0) begin
         e.q = '1; e.sticky = 1'b0; e.dz = 1'b1; e.lat = 0;
         return e;
      end
      num      = 128'(a) << (QW - 2);
      e.q      = QW'(num / 128'(b));
      e.sticky = (num % 128'(b)) != 0;
      e.dz     = 1'b0;
      e.lat    = FULL;
      if (EE && !e.sticky && e.q != '0) begin
         k = 0;
         for (int i = QW - 1; i >= 0; i--) if (e.q[i]) k = i;
         e.lat = FULL - k;
      end
      return e;
   endfunction

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
      @(negedge clk);
      a_man = a; b_man = b; in_valid = 1'b1;
      sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Counts rising edges after the accept edge until out_valid is seen.
   task automatic wait_out(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 400) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic pop_out;
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
   endtask

   task automatic test_reset;
      #3;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_chk++; if (q !== '0) begin n_fail++; $display("FAIL reset_q got %h want 0", q); end
      n_chk++; if ({sticky, div_zero} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {sticky, div_zero}); end
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_ops;
      for (int i = 0; i < 12; i++) begin
         logic [W-1:0] a, b;
         exp_t e, x;
         int lat;
         case (i)
            0: begin a = 24'h800000; b = 24'h800000; e = '{48'h4000_0000_0000, 1'b0, 1'b0, EE ? 1 : FULL}; end
            1: begin a = 24'hC00000; b = 24'h800000; e = '{48'h6000_0000_0000, 1'b0, 1'b0, EE ? 2 : FULL}; end
            2: begin a = 24'h800000; b = 24'hC00000; e = '{48'h2AAA_AAAA_AAAA, 1'b1, 1'b0, FULL}; end
            3: begin a = 24'hFFFFFF; b = 24'h800000; e = '{48'h7FFF_FF80_0000, 1'b0, 1'b0, EE ? 24 : FULL}; end
            default: begin
               a = {1'b1, 23'($urandom)};
               b = {1'b1, 23'($urandom)};
               e = model(a, b);
            end
         endcase
         send(a, b, e);
         wait_out(lat);
         x = sb.pop_front();
         n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL op%0d_timeout out_valid %b want 1", i, out_valid); end
         n_chk++; if (q !== x.q) begin n_fail++; $display("FAIL op%0d_q a=%h b=%h got %h want %h", i, a, b, q, x.q); end
         n_chk++; if (sticky !== x.sticky) begin n_fail++; $display("FAIL op%0d_sticky got %b want %b", i, sticky, x.sticky); end
         n_chk++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL op%0d_div_zero got %b want 0", i, div_zero); end
         n_chk++; if (lat != x.lat) begin n_fail++; $display("FAIL op%0d_latency got %0d want %0d", i, lat, x.lat); end
         pop_out;
      end
   endtask

   task automatic test_div_zero;
      exp_t x;
      int lat;
      send(24'h800000, 24'h000000, '{'1, 1'b0, 1'b1, 0});
      wait_out(lat);
      x = sb.pop_front();
      n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dz_timeout out_valid %b want 1", out_valid); end
      n_chk++; if (q !== x.q) begin n_fail++; $display("FAIL dz_q got %h want %h", q, x.q); end
      n_chk++; if ({div_zero, sticky} !== {x.dz, x.sticky}) begin n_fail++; $display("FAIL dz_flags got %b want %b", {div_zero, sticky}, {x.dz, x.sticky}); end
      // Result is already valid in the cycle right after the accept edge.
      n_chk++; if (lat != x.lat) begin n_fail++; $display("FAIL dz_latency got %0d want %0d", lat, x.lat); end
      pop_out;
   endtask

   task automatic test_back_to_back;
      exp_t x;
      int lat;
      send(24'h800000, 24'hC00000, '{48'h2AAA_AAAA_AAAA, 1'b1, 1'b0, FULL});
      wait_out(lat);
      x = sb.pop_front();
      n_chk++; if (q !== x.q || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_q got %h/%b want %h/1", q, out_valid, x.q); end
      @(negedge clk);
      a_man = 24'hA00000; b_man = 24'h900000; in_valid = 1'b1;
      sb.push_back(model(24'hA00000, 24'h900000));
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid cyc%0d got %b want 1", c, out_valid); end
         n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc%0d got %b want 0", c, in_ready); end
         n_chk++; if (q !== x.q) begin n_fail++; $display("FAIL bp_hold_q cyc%0d got %h want %h", c, q, x.q); end
      end
      out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_single_pop out_valid %b want 0", out_valid); end
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle_ready got %b want 1", in_ready); end
      @(posedge clk); #1; in_valid = 1'b0;
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept in_ready %b want 0", in_ready); end
      wait_out(lat);
      x = sb.pop_front();
      n_chk++; if (q !== x.q || sticky !== x.sticky) begin n_fail++; $display("FAIL b2b_result got %h/%b want %h/%b", q, sticky, x.q, x.sticky); end
      n_chk++; if (lat != x.lat) begin n_fail++; $display("FAIL b2b_latency got %0d want %0d", lat, x.lat); end
      pop_out;
   endtask

   task automatic test_reset_mid_calc;
      exp_t x;
      int lat, seen;
      send(24'h800000, 24'hC00000, '{48'h2AAA_AAAA_AAAA, 1'b1, 1'b0, FULL});
      repeat (20) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      sb.delete();
      n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_hs got %b%b want 10", in_ready, out_valid); end
      n_chk++; if (q !== '0) begin n_fail++; $display("FAIL rst_mid_q got %h want 0", q); end
      n_chk++; if ({sticky, div_zero} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_flags got %b want 00", {sticky, div_zero}); end
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      seen = 0;
      repeat (60) begin @(negedge clk); if (out_valid === 1'b1) seen++; end
      n_chk++; if (seen != 0) begin n_fail++; $display("FAIL rst_mid_no_valid got %0d want 0", seen); end
      send(24'hC00000, 24'h800000, '{48'h6000_0000_0000, 1'b0, 1'b0, EE ? 2 : FULL});
      wait_out(lat);
      x = sb.pop_front();
      n_chk++; if (q !== x.q || sticky !== x.sticky || out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_after_op got %h/%b/%b want %h/%b/1", q, sticky, out_valid, x.q, x.sticky); end
      n_chk++; if (lat != x.lat) begin n_fail++; $display("FAIL rst_after_latency got %0d want %0d", lat, x.lat); end
      pop_out;
   endtask

   initial begin
      test_reset;
      test_ops;
      test_div_zero;
      test_back_to_back;
      test_reset_mid_calc;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
